// File: rtl/dmem_pkg.sv
// Shared types and helpers for the DMEM responder: FSM states, decoded request record
// and byte-enable expansion.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Widest word index a 32-bit byte address can produce.
  localparam int unsigned DMEM_IDX_W = 30;

  typedef struct packed {
    logic                  we;
    logic [3:0]            be;
    logic [DMEM_IDX_W-1:0] idx;
    logic [31:0]           wdata;
    logic                  fault;
  } dmem_req_s;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port WORDS x 32 SRAM with byte-masked writes and a registered read port.
// Contents are never reset.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;
  logic [31:0] mask;

  assign mask = be_to_mask(be_i);

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= (mem_q[idx_i] & ~mask) | (wdata_i & mask);
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, one-outstanding memory responder over a byte-write SRAM.
// Optional DMEM_RESP_STALL_EN adds 0..3 LFSR-driven stall cycles per request.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_fault,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam int unsigned CW   = $clog2(LATENCY + 4) + 1;
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;

  dmem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_load;
  logic          rsp_we_q, rsp_fault_q;
  logic [31:0]   stat_reads_q, stat_writes_q;
  logic [31:0]   sram_rdata;
  logic [32:0]   off;
  logic          accept;
  logic [1:0]    extra;
  dmem_req_s     req_c;
  logic          unused_ok;

  assign accept = mem_req && (state_q == IDLE || state_q == RESP);

  // 33-bit subtraction: a borrow means the address lies below BASE_ADDR.
  assign off = {1'b0, mem_addr} - {1'b0, BASE_ADDR};

  always_comb begin
    req_c       = '0;
    req_c.we    = mem_we;
    req_c.be    = mem_be;
    req_c.idx   = DMEM_IDX_W'(off[AW+1:2]);
    req_c.wdata = mem_wdata;
    req_c.fault = off[32] || (off >= SPAN);
  end

  assign unused_ok = ^{off[1:0], req_c.idx[DMEM_IDX_W-1:AW]};

`ifdef DMEM_RESP_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = '0;
`endif

  assign cnt_load = CW'(LATENCY - 1) + CW'(extra);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q <= CW'(1)) state_d = RESP;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An accept in IDLE or RESP restarts the countdown; zero remaining cycles skips WAIT.
    if (accept) begin
      cnt_d   = cnt_load;
      state_d = (cnt_load == '0) ? RESP : WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rsp_we_q      <= 1'b0;
      rsp_fault_q   <= 1'b0;
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rsp_we_q    <= req_c.we;
        rsp_fault_q <= req_c.fault;
      end
      if (state_q == RESP && !rsp_fault_q) begin
        if (rsp_we_q) stat_writes_q <= stat_writes_q + 32'd1;
        else          stat_reads_q  <= stat_reads_q + 32'd1;
      end
    end
  end

  dmem_sram_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .en_i    (accept && !req_c.fault),
    .we_i    (req_c.we),
    .be_i    (req_c.be),
    .idx_i   (req_c.idx[AW-1:0]),
    .wdata_i (req_c.wdata),
    .rdata_o (sram_rdata)
  );

  assign mem_rvalid  = (state_q == RESP);
  assign mem_fault   = mem_rvalid && rsp_fault_q;
  assign mem_rdata   = (mem_rvalid && !rsp_we_q && !rsp_fault_q) ? sram_rdata : '0;
  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;

endmodule
